// File: rtl/irq_pkg.sv
// Shared definitions for the priority interrupt controller.
// Holds the line count, id width and FSM state encoding.
package irq_pkg;

    localparam int unsigned N_IRQ = 8;
    localparam int unsigned ID_W  = 3;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

endpackage

// File: rtl/irq_prio_enc8.sv
// Combinational 8-to-3 priority encoder: reports the highest set index.
// The any flag is high when at least one input bit is set.
module irq_prio_enc8
    import irq_pkg::*;
(
    input  logic [7:0] in_vec,
    output logic [2:0] id,
    output logic       any
);

    // Ascending scan so the highest set bit is the last one written.
    always_comb begin
        id  = '0;
        any = |in_vec;
        for (int unsigned i = 0; i < 8; i++) begin
            if (in_vec[i]) begin
                id = i[2:0];
            end
        end
    end

endmodule

// File: rtl/priority_irq_ctrl.sv
// Priority interrupt controller with sticky pending bits and a
// two-state present/acknowledge handshake. Line 7 has highest priority.
// Optional feature: define IRQ_MASK_EN to add the per-line mask input.
module priority_irq_ctrl
    import irq_pkg::*;
#(
    parameter int unsigned N_IRQ = irq_pkg::N_IRQ,
    parameter int unsigned ID_W  = irq_pkg::ID_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IRQ-1:0] req,
`ifdef IRQ_MASK_EN
    input  logic [N_IRQ-1:0] mask,
`endif
    input  logic             irq_ack,
    output logic             irq_valid,
    output logic [ID_W-1:0]  irq_id,
    output logic [N_IRQ-1:0] pending
);

    state_t           state_q, state_d;
    logic [N_IRQ-1:0] req_q, req_d;
    logic [N_IRQ-1:0] pending_q, pending_d;
    logic             irq_valid_q, irq_valid_d;
    logic [ID_W-1:0]  irq_id_q, irq_id_d;

    logic [N_IRQ-1:0] enabled;
    logic [N_IRQ-1:0] rise;
    logic [N_IRQ-1:0] ack_clr_vec;
    logic             ack_clr;
    logic [ID_W-1:0]  enc_id;
    logic             enc_any;

`ifdef IRQ_MASK_EN
    assign enabled = mask;
`else
    assign enabled = '1;
`endif

    irq_prio_enc8 u_enc (
        .in_vec (pending_q & enabled),
        .id     (enc_id),
        .any    (enc_any)
    );

    // Edge detection and sticky pending: a new rising edge wins over an ack clear.
    always_comb begin
        req_d       = req;
        rise        = req & ~req_q;
        ack_clr_vec = '0;
        if (ack_clr) begin
            ack_clr_vec[irq_id_q] = 1'b1;
        end
        pending_d = (pending_q & ~ack_clr_vec) | rise;
    end

    // Next-state and output logic: load the winner in IDLE, hold it until ack in PRESENT.
    always_comb begin
        state_d     = state_q;
        irq_valid_d = irq_valid_q;
        irq_id_d    = irq_id_q;
        ack_clr     = 1'b0;
        case (state_q)
            IDLE: begin
                irq_valid_d = 1'b0;
                if (enc_any) begin
                    irq_id_d    = enc_id;
                    irq_valid_d = 1'b1;
                    state_d     = PRESENT;
                end
            end
            PRESENT: begin
                if (irq_ack) begin
                    ack_clr     = 1'b1;
                    irq_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                irq_valid_d = 1'b0;
            end
        endcase
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            req_q       <= '0;
            pending_q   <= '0;
            irq_valid_q <= 1'b0;
            irq_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            pending_q   <= pending_d;
            irq_valid_q <= irq_valid_d;
            irq_id_q    <= irq_id_d;
        end
    end

    assign irq_valid = irq_valid_q;
    assign irq_id    = irq_id_q;
    assign pending   = pending_q;

endmodule

// File: doc/priority_irq_ctrl.md
PRIORITY_IRQ_CTRL -- requirements
Module: priority_irq_ctrl

Interface
REQ-001 Parameter N_IRQ, default 8, SHALL set the number of request lines; only 8 is supported.
REQ-002 Parameter ID_W, default 3, SHALL set the width of the encoded id and SHALL equal log2(N_IRQ).
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  SHALL be the reset, synchronous and active-high.
REQ-005 req  input  N_IRQ  SHALL carry the raw interrupt request lines; a bit is active when high.
REQ-006 mask  input  N_IRQ  SHALL enable each line when high; this port SHALL exist only under IRQ_MASK_EN.
REQ-007 irq_ack  input  1  SHALL be the consumer acknowledgement of the presented id.
REQ-008 irq_valid  output  1  SHALL be high while an id is presented.
REQ-009 irq_id  output  ID_W  SHALL carry the presented line index; 7 is the highest priority.
REQ-010 pending  output  N_IRQ  SHALL expose the sticky pending register.

Function
REQ-011 The block SHALL register req into req_q every cycle.
REQ-012 At each edge, for every i with req[i]=1 and req_q[i]=0, pending[i] SHALL be set.
REQ-013 A pending bit SHALL stay set until it is cleared by an acknowledge of its id.
REQ-014 The FSM SHALL have two states, IDLE and PRESENT, and SHALL reset to IDLE.
REQ-015 In IDLE, when (pending & enabled) is nonzero, the block SHALL load irq_id with the highest set index, set irq_valid, and go to PRESENT at that edge.
REQ-016 In IDLE with (pending & enabled) = 0, irq_valid SHALL be 0 and irq_id SHALL hold its last value.
REQ-017 In PRESENT, irq_id SHALL be stable, with no preemption even if a higher-priority line becomes pending.
REQ-018 In PRESENT with irq_ack=1, the block SHALL clear pending[irq_id], clear irq_valid and go to IDLE at that edge.
REQ-019 irq_ack SHALL be ignored in IDLE.
REQ-020 A new edge on line irq_id in the same cycle as its ack SHALL leave pending[irq_id] set, because set wins over clear.
REQ-021 Latency: a rising edge on req sampled at edge k SHALL give irq_valid=1 after edge k+1 when the FSM is IDLE and no higher line is pending.
REQ-022 Back-to-back service SHALL take at most one IDLE cycle between presentations.
REQ-023 A level held high SHALL register only once; it SHALL re-arm only after going low for at least one cycle.

Reset
REQ-024 While rst=1 at an edge: pending=0, req_q=0, state=IDLE, irq_valid=0, irq_id=0.
REQ-025 Reset SHALL override any simultaneous req edge or ack, including mid-presentation.
REQ-026 A req bit already high on the first edge after reset release SHALL count as a rising edge.

Configuration
REQ-027 With IRQ_MASK_EN defined, enabled=mask, and a masked line SHALL still set pending without being presented until it is unmasked.
REQ-028 Without IRQ_MASK_EN, the mask port SHALL be absent and enabled SHALL be all ones.
REQ-029 Clearing a mask bit while PRESENT SHALL NOT withdraw the id already presented.

Structure
REQ-030 N_IRQ, ID_W and the FSM state enum (IDLE, PRESENT) SHALL live in the shared package irq_pkg.
REQ-031 The combinational highest-index encoder SHALL be a sub-module named irq_prio_enc8 (8-bit in, 3-bit id out, any-flag out).

Verification
REQ-032 Pulse req=8'h04 for one cycle -> pending=8'h04, then irq_valid=1 with id=2 one edge later; ack -> pending=0, valid=0.
REQ-033 req=8'h81 simultaneously -> id=7 first; ack -> next id=0; ack -> idle with pending=0.
REQ-034 While presenting id=1, pulse req[6] -> id stays 1 until ack, then id=6 is presented.
REQ-035 Ack of id=3 while req[3] rises in the same cycle -> pending[3] stays 1 and id=3 is re-presented.
REQ-036 (IRQ_MASK_EN) mask=8'h00, pulse req[5] -> pending=8'h20 with valid=0; set mask=8'hFF -> id=5 is presented.
REQ-037 Assert rst while PRESENT with pending=8'h30 -> next edge pending=0, valid=0, id=0, and no presentation afterwards.
